srd_rst_rsp: RTL

//  Responder end of the serdes reset req/ack handshake. Takes the active-low

---
 rtl/srd_rst_rsp.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/srd_rst_rsp.sv
// Responder end of the serdes reset req/ack handshake: holds the lane datapath
// in reset on request, acks, and releases once the request drops and the PLL locks.
module srd_rst_rsp #(
  parameter int SYNC_STAGES  = 2,
  parameter int RST_HOLD_CYC = 16,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rst_n,
  output logic o_rst_ack_n,
  input  logic i_pll_locked,
  output logic o_core_rst,
  output logic o_ready,
  output logic o_timeout
);

  localparam int CNT_MAX = (RST_HOLD_CYC > LOCK_TIMEOUT) ? RST_HOLD_CYC : LOCK_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD_CYC - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    WAIT_REQ,
    HOLD,
    ACK,
    LOCK,
    DEASSERT,
    RUN
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   ack_n_q, ack_n_d;
  logic                   core_rst_q, core_rst_d;
  logic                   ready_q, ready_d;
  logic                   timeout_q, timeout_d;
  logic [SYNC_STAGES-1:0] req_sync_q;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   req;
  logic                   lock;

  // Synchronizers preset to "no request, no lock" so reset never looks like a request.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      req_sync_q  <= '1;
      lock_sync_q <= '0;
    end else begin
      req_sync_q  <= {req_sync_q[SYNC_STAGES-2:0], i_rst_n};
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], i_pll_locked};
    end
  end

  assign req  = req_sync_q[SYNC_STAGES-1];
  assign lock = lock_sync_q[SYNC_STAGES-1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= WAIT_REQ;
      cnt_q      <= '0;
      ack_n_q    <= 1'b1;
      core_rst_q <= 1'b1;
      ready_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ack_n_q    <= ack_n_d;
      core_rst_q <= core_rst_d;
      ready_q    <= ready_d;
      timeout_q  <= timeout_d;
    end
  end

  // cnt_d defaults to zero so every state entry starts the shared counter fresh.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    ack_n_d    = ack_n_q;
    core_rst_d = core_rst_q;
    ready_d    = ready_q;
    timeout_d  = timeout_q;
    case (state_q)
      WAIT_REQ: begin
        core_rst_d = 1'b1;
        ack_n_d    = 1'b1;
        ready_d    = 1'b0;
        if (!req) state_d = HOLD;
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          ack_n_d = 1'b0;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACK: begin
        ack_n_d    = 1'b0;
        core_rst_d = 1'b1;
        if (req) state_d = LOCK;
      end
      // A re-asserted request outranks lock: the sequencer still owns the lane.
      LOCK: begin
        if (!req) begin
          state_d = ACK;
        end else if (lock) begin
          core_rst_d = 1'b0;
          state_d    = DEASSERT;
        end else if (cnt_q == LOCK_LAST) begin
          timeout_d  = 1'b1;
          core_rst_d = 1'b0;
          state_d    = DEASSERT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DEASSERT: begin
        ack_n_d = 1'b1;
        ready_d = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (!req) begin
          core_rst_d = 1'b1;
          ready_d    = 1'b0;
          state_d    = HOLD;
        end
      end
      default: begin
        state_d    = WAIT_REQ;
        ack_n_d    = 1'b1;
        core_rst_d = 1'b1;
        ready_d    = 1'b0;
      end
    endcase
  end

  assign o_rst_ack_n = ack_n_q;
  assign o_core_rst  = core_rst_q;
  assign o_ready     = ready_q;
  assign o_timeout   = timeout_q;

endmodule
